// File: rtl/serial_rx_deserializer_pkg.sv
// Shared definitions for the serial character link.
// Holds the receive FSM state encoding, the frame length and the frame
// field indices. The transmit side uses the same field indices.
package serial_rx_deserializer_pkg;

    localparam int FRAME_BITS = 10;

    // Bit positions inside a 10-bit frame
    localparam int START_IDX = 0;
    localparam int DATA_LSB  = 1;
    localparam int DATA_MSB  = 8;
    localparam int STOP_IDX  = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/serial_rx_deserializer_bit_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to 1 so an idle (high) serial line is not mistaken for
// a start bit right after reset.
// Ports:
//   clk_i   - sampling clock
//   reset_i - synchronous active-high reset
//   d_i     - asynchronous input
//   q_o     - synchronized output (2 cycles of latency)
module bit_sync2 (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/serial_rx_deserializer.sv
// Receive front end of the serial character link.
// Oversamples data_in, validates the start bit at mid-bit, shifts in a
// 10-bit frame (start, 8 data bits LSB first, stop) and presents it as a
// parallel word with sticky status flags for the processor PIOs.
// Ports:
//   clk                - divided system clock
//   reset              - synchronous active-high reset
//   data_in            - asynchronous serial line, idle high
//   char_ack           - one-cycle pulse clearing the three sticky flags
//   parallel_out       - last completed frame {stop, data[7:0], start}
//   character_received - an unacknowledged frame is held
//   framing_error      - the held frame had a 0 stop bit
//   overrun            - a frame completed while one was still held
//   busy               - receiver is not idle
module serial_rx_deserializer
    import serial_rx_deserializer_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_in,
    input  logic                  char_ack,
    output logic [FRAME_BITS-1:0] parallel_out,
    output logic                  character_received,
    output logic                  framing_error,
    output logic                  overrun,
    output logic                  busy
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);

    logic                  rx_s;
    rx_state_e             state_q;
    logic [TW-1:0]         tick_q;
    logic [3:0]            bit_cnt_q;
    logic [DATA_MSB:0]     shift_q;
    logic [FRAME_BITS-1:0] parallel_out_q;
    logic                  char_rx_q;
    logic                  frame_err_q;
    logic                  overrun_q;
    logic                  frame_done_d;

    bit_sync2 u_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (data_in),
        .q_o     (rx_s)
    );

    // Stop bit is being sampled this cycle; outputs update on this edge.
    assign frame_done_d = (state_q == STOP) && (tick_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            tick_q         <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            parallel_out_q <= '0;
            char_rx_q      <= 1'b0;
            frame_err_q    <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;

            case (state_q)
                IDLE: begin
                    tick_q    <= '0;
                    bit_cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= START;
                    end
                end
                START: begin
                    // Mid-bit check rejects short low glitches
                    if (tick_q == TICK_MID) begin
                        if (rx_s) begin
                            state_q <= IDLE;
                        end else begin
                            shift_q[START_IDX] <= rx_s;
                            bit_cnt_q          <= 4'(DATA_LSB);
                            tick_q             <= '0;
                            state_q            <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick_q == TICK_LAST) begin
                        shift_q[bit_cnt_q] <= rx_s;
                        bit_cnt_q          <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 4'(DATA_MSB)) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Completion takes priority over a coincident acknowledge
            if (frame_done_d) begin
                parallel_out_q[STOP_IDX]           <= rx_s;
                parallel_out_q[DATA_MSB:START_IDX] <= shift_q;
                char_rx_q                          <= 1'b1;
                frame_err_q                        <= ~rx_s;
                overrun_q <= char_ack ? 1'b0 : (overrun_q | char_rx_q);
            end else if (char_ack) begin
                char_rx_q   <= 1'b0;
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end
        end
    end

    assign parallel_out       = parallel_out_q;
    assign character_received = char_rx_q;
    assign framing_error      = frame_err_q;
    assign overrun            = overrun_q;
    assign busy               = (state_q != IDLE);

endmodule

// File: doc/serial_rx_deserializer.md
Name: serial_rx_deserializer

Overview:
Receive front end for the serial character link. Oversamples the asynchronous `data_in` line and detects and validates the start bit. Shifts in a 10-bit frame (start, 8 data LSB-first, stop) and presents it as a parallel word with a sticky "character received" flag for the Nios parallel input ports. It sits directly upstream of the processor's `paralleltoprocessor` and `characterreceived` PIOs and is clocked by the divided clock chosen at top level.

Parameters:
- `OVERSAMPLE`, 16, clk cycles per serial bit period; must be even and ≥4.
- `FRAME_BITS`, 10, total bits per frame including start and stop; fixed at 10 for this link.

Ports:
- `clk`  in  1  divided system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  1  asynchronous serial line; idle high.
- `char_ack`  in  1  one-cycle pulse from processor side; clears `character_received`, `framing_error` and `overrun`.
- `parallel_out`  out  10  last captured frame: [0]=start, [8:1]=data (bit1 = first data bit received), [9]=stop.
- `character_received`  out  1  sticky; high while an unacknowledged frame is held.
- `framing_error`  out  1  sticky; stop bit sampled 0 on the held frame.
- `overrun`  out  1  sticky; a frame completed while `character_received` was already high.
- `busy`  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset values:
  - `parallel_out`=0, all flags 0, `busy`=0, FSM=IDLE, counters 0.
  - Synchronizer flops reset to 1 (idle line).
  - Reset mid-frame discards the partial frame; no flag is raised.
- Synchronizer: two flops on `data_in` give `rx_s`. All decisions use `rx_s`, so there are 2 cycles of input latency.
- Counters:
  - `tick_cnt` counts 0..OVERSAMPLE-1 and wraps.
  - `bit_cnt` counts 0..FRAME_BITS-1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when `rx_s`=0, go to START and set `tick_cnt`=0.
  - START: at `tick_cnt`=OVERSAMPLE/2-1 (mid-bit), sample `rx_s`.
    - If 1, treat as a glitch and return to IDLE with no output change.
    - If 0, store the start bit, set `bit_cnt`=1, reset `tick_cnt`, and go to DATA.
  - DATA: each time `tick_cnt`=OVERSAMPLE-1, sample `rx_s` into shift register position `bit_cnt` and increment `bit_cnt`. After bit 8 is stored, go to STOP.
  - STOP: at `tick_cnt`=OVERSAMPLE-1, sample the stop bit and complete the frame, then go to IDLE.
    - A new start is accepted from the next cycle.
    - Back-to-back frames need no idle gap.
- Frame completion (cycle after the stop sample):
  - `parallel_out` loads the full frame.
  - `character_received` is set.
  - `framing_error` is set if the stop bit is 0. The frame is still delivered.
  - If `character_received` was already 1, `overrun` is set and `parallel_out` is overwritten with the new frame.
- `parallel_out` is stable between completions and never shows partial shifting.
- `char_ack` clears all three flags on the next edge.
  - If `char_ack` and a frame completion occur in the same cycle, completion wins: `character_received`=1, `overrun`=0, and `framing_error` reflects the new frame.
- Frame latency: from the synchronized start falling edge to `character_received` high is OVERSAMPLE/2 + 9·OVERSAMPLE + 1 cycles (+2 for the synchronizer).

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - `FRAME_BITS`.
  - Frame field indices: START_IDX=0, DATA_LSB=1, DATA_MSB=8, STOP_IDX=9.
  - The same indices serve the transmit side.
- One natural sub-module, `bit_sync2`: the two-flop synchronizer with reset-to-1. Everything else stays in one module.

Test Plan:
1. OVERSAMPLE=16. Send 0x41 with stop=1 → `parallel_out`=10'h282 and `character_received`=1, exactly 16·9+8+1+2=155 cycles after the `data_in` falling edge. `framing_error`=0.
2. Drive `data_in` low for 5 cycles, then high → FSM returns to IDLE. No flag is set, `parallel_out` is unchanged, and `busy` drops by cycle 8 after the synchronizer.
3. Send 0x55 with stop bit 0 → `parallel_out`=10'h0AA, `character_received`=1, `framing_error`=1.
4. Send 0x12 then 0x34 back-to-back with no ack → `parallel_out`=10'h268, `overrun`=1. Pulse `char_ack` → all flags 0 next cycle, and `parallel_out` holds 10'h268.
5. Assert `reset` for 1 cycle at data bit 4 of a frame → all outputs 0 and `busy`=0. A following valid 0xA5 frame gives `parallel_out`=10'h34A.
6. Pulse `char_ack` in the same cycle as completion of frame 0x7E → `character_received`=1, `overrun`=0, `parallel_out`=10'h2FC.
